// File: rtl/interrupt_controller_pkg.sv
// ============================================================================
// intc_pkg : shared types, register offsets and sizing helper for the
//            interrupt controller.      Rev 1.0
// ============================================================================
`default_nettype none

package intc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [1:0] OFF_MASK   = 2'd0;
  localparam logic [1:0] OFF_PEND   = 2'd1;
  localparam logic [1:0] OFF_SWTRIG = 2'd2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << w) < 33'(n)) w = w + 1;
    end
    return w;
  endfunction

  // A single source still needs a one-bit index
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_if.sv
// ============================================================================
// intc_if : core-side interrupt handshake plus register bus of the
//           interrupt controller.      Rev 1.0
// ============================================================================
`default_nettype none

interface intc_if #(
  parameter int M = 16,
  parameter int N = 32
) ();

  logic         irq;
  logic [N-1:0] intAddr;
  logic [M-1:0] intData;
  logic         turnOffIRQ;
  logic [N-1:0] busAddr;
  logic [M-1:0] busWrite;
  logic         busWE;
  logic         busRE;
  logic [M-1:0] busRead;
  logic         busHit;

  modport slave (
    output irq, intAddr, intData, busRead, busHit,
    input  turnOffIRQ, busAddr, busWrite, busWE, busRE
  );

  modport master (
    input  irq, intAddr, intData, busRead, busHit,
    output turnOffIRQ, busAddr, busWrite, busWE, busRE
  );

endinterface

`default_nettype wire

// File: rtl/interrupt_controller_prio_enc.sv
// ============================================================================
// intc_prio_enc : combinational priority encoder, lowest index wins.
//                 Rev 1.0
// ============================================================================
`default_nettype none

module intc_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int IW      = 3
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// interrupt_controller : edge-latched, maskable, lowest-index-first interrupt
//   controller for the rcpu core. Optional macro INTC_SWTRIG_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module interrupt_controller
  import intc_pkg::*;
#(
  parameter int           NUM_SRC   = 8,
  parameter int           M         = 16,
  parameter int           N         = 32,
  parameter logic [N-1:0] BASE_ADDR = 32'hE000_0000,
  parameter logic [N-1:0] VEC_BASE  = 32'h0000_0100,
  parameter int           VEC_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  intc_if.slave              bus
);

  localparam int IW = idx_width(NUM_SRC);

  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] sw_set;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pend_next;
  logic [NUM_SRC-1:0] enabled;
  logic [N-1:0]       off;
  logic               hit;
  logic               wr_mask;
  logic               wr_pend;
  logic [M-1:0]       rd_data;
  state_t             state;
  logic [IW-1:0]      cur;
  logic [IW-1:0]      win_idx;
  logic               win_valid;
  logic               irq_q;

  // Subtracting first keeps the window check correct near address wrap
  assign off        = bus.busAddr - BASE_ADDR;
  assign hit        = (off < N'(3));
  assign bus.busHit = hit;
  assign wdata      = NUM_SRC'(bus.busWrite);
  assign wr_mask    = bus.busWE && hit && (off[1:0] == OFF_MASK);
  assign wr_pend    = bus.busWE && hit && (off[1:0] == OFF_PEND);

  assign edges   = src & ~src_prev;
  assign w1c     = wr_pend ? wdata : '0;
  assign ack_clr = (state == REQ && bus.turnOffIRQ) ? (NUM_SRC'(1) << cur) : '0;

`ifdef INTC_SWTRIG_EN
  logic wr_sw;
  assign wr_sw  = bus.busWE && hit && (off[1:0] == OFF_SWTRIG);
  assign sw_set = wr_sw ? wdata : '0;
`else
  assign sw_set = '0;
`endif

  // Sets are applied after clears so a coinciding set always survives
  assign pend_next = (pending & ~(w1c | ack_clr)) | edges | sw_set;
  assign enabled   = pending & mask;

  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_prio (
    .req   (enabled),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_prev <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      src_prev <= src;
      pending  <= pend_next;
      if (wr_mask) mask <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cur   <= '0;
      irq_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            cur   <= win_idx;
            state <= REQ;
            irq_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.turnOffIRQ) begin
            state <= ACK;
            irq_q <= 1'b0;
          end
        end
        ACK: begin
          if (!bus.turnOffIRQ) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq     = irq_q;
  assign bus.intAddr = VEC_BASE + (N'(cur) << VEC_SHIFT);
  assign bus.intData = M'(cur);

  always_comb begin
    rd_data = '0;
    if (hit && bus.busRE) begin
      case (off[1:0])
        OFF_MASK: rd_data[NUM_SRC-1:0] = mask;
        OFF_PEND: rd_data[NUM_SRC-1:0] = pending;
        default:  rd_data = '0;
      endcase
    end
  end

  assign bus.busRead = rd_data;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// tb_interrupt_controller : directed plus randomized bench with a behavioural
//   reference model of the interrupt controller.      Rev 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

  localparam int          NUM_SRC = 8;
  localparam int          M       = 16;
  localparam int          N       = 32;
  localparam logic [31:0] BASE    = 32'hE000_0000;
  localparam logic [31:0] VEC     = 32'h0000_0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src = 8'h00;
  logic       cmp_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  intc_if #(.M(M), .N(N)) bus_if ();

  interrupt_controller #(
    .NUM_SRC   (NUM_SRC),
    .M         (M),
    .N         (N),
    .BASE_ADDR (BASE),
    .VEC_BASE  (VEC),
    .VEC_SHIFT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state: phase 0 idle, 1 requesting, 2 waiting for ack release
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_ACK  = 2;
  int         m_phase = P_IDLE;
  int         m_cur   = 0;
  logic [7:0] m_pend  = 8'h00;
  logic [7:0] m_mask  = 8'h00;
  logic [7:0] m_prev  = 8'h00;
  logic [7:0] m_edges, m_clr, m_set;
  int         m_off, m_low;
  bit         m_wr;
  logic [15:0] exp_rd;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd2);
  endfunction

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_cur = 0; m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
    end else begin
      m_edges = src & ~m_prev;
      m_prev  = src;
      m_wr    = bus_if.busWE && in_win(bus_if.busAddr);
      m_off   = int'(bus_if.busAddr - BASE);
      m_clr   = (m_wr && m_off == 1) ? bus_if.busWrite[7:0] : 8'h00;
      m_set   = m_edges;
`ifdef INTC_SWTRIG_EN
      if (m_wr && m_off == 2) m_set = m_set | bus_if.busWrite[7:0];
`endif
      case (m_phase)
        P_IDLE: begin
          m_low = lowest(m_pend & m_mask);
          if (m_low >= 0) begin m_cur = m_low; m_phase = P_REQ; end
        end
        P_REQ: if (bus_if.turnOffIRQ) begin m_clr[m_cur] = 1'b1; m_phase = P_ACK; end
        default: if (!bus_if.turnOffIRQ) m_phase = P_IDLE;
      endcase
      m_pend = (m_pend & ~m_clr) | m_set;
      if (m_wr && m_off == 0) m_mask = bus_if.busWrite[7:0];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("irq", {31'd0, bus_if.irq}, {31'd0, m_phase == P_REQ});
      chk("intAddr", bus_if.intAddr, VEC + 32'(m_cur) * 32'd4);
      chk("intData", {16'd0, bus_if.intData}, 32'(m_cur));
      chk("busHit", {31'd0, bus_if.busHit}, {31'd0, in_win(bus_if.busAddr)});
      exp_rd = 16'h0000;
      if (in_win(bus_if.busAddr) && bus_if.busRE) begin
        if (bus_if.busAddr == BASE)              exp_rd = {8'h00, m_mask};
        else if (bus_if.busAddr == BASE + 32'd1) exp_rd = {8'h00, m_pend};
      end
      chk("busRead", {16'd0, bus_if.busRead}, {16'd0, exp_rd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [15:0] d);
    bus_if.busAddr  = a;
    bus_if.busWrite = d;
    bus_if.busWE    = 1'b1;
    tick();
    bus_if.busWE    = 1'b0;
  endtask

  task automatic bus_rd_chk(input string name, input logic [31:0] a, input logic [15:0] exp);
    bus_if.busAddr = a;
    bus_if.busRE   = 1'b1;
    #1;
    chk(name, {16'd0, bus_if.busRead}, {16'd0, exp});
    bus_if.busRE   = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int maxc);
    int n;
    n = 0;
    while (bus_if.irq !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk(name, {31'd0, bus_if.irq}, 32'd1);
  endtask

  task automatic ack();
    bus_if.turnOffIRQ = 1'b1;
    tick();
    bus_if.turnOffIRQ = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.turnOffIRQ = 1'b0;
    bus_if.busAddr    = 32'h0;
    bus_if.busWrite   = 16'h0;
    bus_if.busWE      = 1'b0;
    bus_if.busRE      = 1'b0;
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("reset_irq", {31'd0, bus_if.irq}, 32'd0);
    chk("reset_intAddr", bus_if.intAddr, 32'h0000_0100);
    chk("reset_intData", {16'd0, bus_if.intData}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Masked source latches as pending without requesting
    src = 8'h08; tick(); src = 8'h00;
    bus_rd_chk("pend_masked", BASE + 32'd1, 16'h0008);
    tick(); tick();
    chk("irq_masked", {31'd0, bus_if.irq}, 32'd0);
    bus_wr(BASE, 16'h0008);
    wait_irq("irq_after_mask", 2);
    chk("vec_src3", bus_if.intAddr, 32'h0000_010C);
    chk("data_src3", {16'd0, bus_if.intData}, 32'h0000_0003);
    ack();

    // Simultaneous edges: lowest index first
    bus_wr(BASE, 16'h00FF);
    src = 8'h24; tick(); src = 8'h00;
    wait_irq("irq_pair", 3);
    chk("data_first", {16'd0, bus_if.intData}, 32'd2);
    bus_if.turnOffIRQ = 1'b1; tick();
    chk("irq_acked", {31'd0, bus_if.irq}, 32'd0);
    bus_rd_chk("pend_after_ack", BASE + 32'd1, 16'h0020);
    bus_if.turnOffIRQ = 1'b0;
    wait_irq("irq_second", 3);
    chk("data_second", {16'd0, bus_if.intData}, 32'd5);
    chk("vec_src5", bus_if.intAddr, 32'h0000_0114);
    ack();

    // Request is not retracted by masking or clearing
    src = 8'h02; tick(); src = 8'h00;
    wait_irq("irq_src1", 3);
    bus_wr(BASE, 16'h0000);
    bus_wr(BASE + 32'd1, 16'h0002);
    tick();
    chk("irq_sticky", {31'd0, bus_if.irq}, 32'd1);
    chk("data_sticky", {16'd0, bus_if.intData}, 32'd1);
    ack();
    chk("irq_after_sticky", {31'd0, bus_if.irq}, 32'd0);
    bus_wr(BASE, 16'h00FF);

    // Long acknowledge with another source waiting
    src = 8'h11; tick(); src = 8'h00;
    wait_irq("irq_src0", 3);
    chk("data_src0", {16'd0, bus_if.intData}, 32'd0);
    bus_if.turnOffIRQ = 1'b1;
    repeat (4) begin
      tick();
      chk("irq_held_ack", {31'd0, bus_if.irq}, 32'd0);
    end
    bus_if.turnOffIRQ = 1'b0;
    tick();
    chk("irq_one_after_drop", {31'd0, bus_if.irq}, 32'd0);
    tick();
    chk("irq_two_after_drop", {31'd0, bus_if.irq}, 32'd1);
    chk("data_src4", {16'd0, bus_if.intData}, 32'd4);
    ack();

    // Software trigger
    bus_wr(BASE, 16'h0001);
    bus_wr(BASE + 32'd2, 16'h0001);
`ifdef INTC_SWTRIG_EN
    wait_irq("irq_swtrig", 2);
    chk("data_swtrig", {16'd0, bus_if.intData}, 32'd0);
    ack();
`else
    tick();
    bus_rd_chk("pend_no_swtrig", BASE + 32'd1, 16'h0000);
    chk("irq_no_swtrig", {31'd0, bus_if.irq}, 32'd0);
`endif
    bus_rd_chk("swtrig_reads_zero", BASE + 32'd2, 16'h0000);
    bus_rd_chk("outside_window", BASE + 32'd3, 16'h0000);

    // Asynchronous reset in the middle of a request
    bus_wr(BASE, 16'h00FF);
    src = 8'h40; tick(); src = 8'h00;
    wait_irq("irq_src6", 3);
    #2 rst = 1'b0;
    #1 chk("irq_async_reset", {31'd0, bus_if.irq}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus_rd_chk("pend_after_reset", BASE + 32'd1, 16'h0000);
    bus_rd_chk("mask_after_reset", BASE, 16'h0000);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      src               = 8'($urandom) & 8'($urandom);
      bus_if.busAddr    = BASE + 32'($urandom_range(0, 4)) - 32'd1;
      bus_if.busWrite   = 16'($urandom);
      bus_if.busWE      = ($urandom_range(0, 9) < 2);
      bus_if.busRE      = ($urandom_range(0, 1) == 1);
      bus_if.turnOffIRQ = ($urandom_range(0, 2) == 0);
      tick();
    end
    src = 8'h00;
    bus_if.busWE = 1'b0;
    bus_if.busRE = 1'b0;
    bus_if.turnOffIRQ = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
